// File: rtl/pipe_stall_ctrl.sv
// Central stall sequencer: merges the ID load-use request with the EX divider and
// MEM SRAM wait-state sequencers, and drives the shared stall bus plus a stall counter.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int MEM_WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        div_req,
  input  logic        mem_req,
  output logic [5:0]  stall,
  output logic        div_start,
  output logic        div_done,
  output logic        mem_rdy,
  output logic [31:0] stall_cnt
);

  localparam int DCNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam int MCNT_W = (MEM_WAIT > 2) ? $clog2(MEM_WAIT) : 1;
  localparam logic [DCNT_W-1:0] DCNT_INIT = DCNT_W'(DIV_CYCLES - 1);
  localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

  typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} d_state_e;
  typedef enum logic       {M_IDLE, M_WAIT} m_state_e;

  d_state_e            d_state_q, d_state_d;
  logic [DCNT_W-1:0]   d_cnt_q, d_cnt_d;
  m_state_e            m_state_q, m_state_d;
  logic [MCNT_W-1:0]   m_cnt_q, m_cnt_d;
  logic [31:0]         stall_cnt_q;

  logic stall_ex, stall_mem;
  logic div_start_c, div_done_c, mem_rdy_c;

  // State registers for both sequencers
  always_ff @(posedge clk) begin
    if (rst) begin
      d_state_q <= D_IDLE;
      d_cnt_q   <= '0;
      m_state_q <= M_IDLE;
      m_cnt_q   <= '0;
    end else begin
      d_state_q <= d_state_d;
      d_cnt_q   <= d_cnt_d;
      m_state_q <= m_state_d;
      m_cnt_q   <= m_cnt_d;
    end
  end

  // Divider next state; D_DONE holds while MEM freezes EX so the result is not lost
  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    case (d_state_q)
      D_IDLE: begin
        if (div_req) begin
          d_state_d = D_BUSY;
          d_cnt_d   = DCNT_INIT;
        end
      end
      D_BUSY: begin
        if (d_cnt_q != '0) d_cnt_d = d_cnt_q - DCNT_W'(1);
        else               d_state_d = D_DONE;
      end
      D_DONE: begin
        if (!stall_mem) d_state_d = D_IDLE;
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  always_comb begin
    stall_ex    = 1'b0;
    div_start_c = 1'b0;
    div_done_c  = 1'b0;
    case (d_state_q)
      D_IDLE: begin
        stall_ex    = div_req;
        div_start_c = div_req;
      end
      D_BUSY:  stall_ex   = 1'b1;
      D_DONE:  div_done_c = 1'b1;
      default: stall_ex   = 1'b0;
    endcase
  end

  // Memory wait-state sequencer; a zero-wait SRAM bypasses it entirely
  always_comb begin
    m_state_d = m_state_q;
    m_cnt_d   = m_cnt_q;
    if (MEM_WAIT != 0) begin
      case (m_state_q)
        M_IDLE: begin
          if (mem_req) begin
            m_state_d = M_WAIT;
            m_cnt_d   = MCNT_INIT;
          end
        end
        M_WAIT: begin
          if (m_cnt_q != '0) m_cnt_d = m_cnt_q - MCNT_W'(1);
          else               m_state_d = M_IDLE;
        end
        default: m_state_d = M_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_mem = 1'b0;
    mem_rdy_c = 1'b0;
    if (MEM_WAIT == 0) begin
      mem_rdy_c = mem_req;
    end else begin
      case (m_state_q)
        M_IDLE: stall_mem = mem_req;
        M_WAIT: begin
          stall_mem = (m_cnt_q != '0);
          mem_rdy_c = (m_cnt_q == '0);
        end
        default: stall_mem = 1'b0;
      endcase
    end
  end

  // Stall bus: the latest stalled stage wins. Reset masks everything so an
  // aborted operation never leaks a strobe.
  always_comb begin
    stall = 6'b000000;
    if (!rst) begin
      if (stall_mem)        stall = 6'b011111;
      else if (stall_ex)    stall = 6'b001111;
      else if (stallreq_id) stall = 6'b000111;
    end
  end

  assign div_start = div_start_c & ~rst;
  assign div_done  = div_done_c  & ~rst;
  assign mem_rdy   = mem_rdy_c   & ~rst;

  always_ff @(posedge clk) begin
    if (rst)                                          stall_cnt_q <= '0;
    else if ((stall != 6'b0) && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: four parameterisations share one stimulus bus,
// each section resets first and checks only the instance it targets.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst, stallreq_id, div_req, mem_req;

  logic [5:0]  stall_a, stall_b, stall_c, stall_d;
  logic        start_a, start_b, start_c, start_d;
  logic        done_a, done_b, done_c, done_d;
  logic        rdy_a, rdy_b, rdy_c, rdy_d;
  logic [31:0] cnt_a, cnt_b, cnt_c, cnt_d;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_CYCLES(4), .MEM_WAIT(2)) u_a (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .div_req(div_req), .mem_req(mem_req),
    .stall(stall_a), .div_start(start_a), .div_done(done_a), .mem_rdy(rdy_a), .stall_cnt(cnt_a));
  pipe_stall_ctrl #(.DIV_CYCLES(1), .MEM_WAIT(3)) u_b (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .div_req(div_req), .mem_req(mem_req),
    .stall(stall_b), .div_start(start_b), .div_done(done_b), .mem_rdy(rdy_b), .stall_cnt(cnt_b));
  pipe_stall_ctrl #(.DIV_CYCLES(32), .MEM_WAIT(2)) u_c (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .div_req(div_req), .mem_req(mem_req),
    .stall(stall_c), .div_start(start_c), .div_done(done_c), .mem_rdy(rdy_c), .stall_cnt(cnt_c));
  pipe_stall_ctrl #(.DIV_CYCLES(2), .MEM_WAIT(0)) u_d (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .div_req(div_req), .mem_req(mem_req),
    .stall(stall_d), .div_start(start_d), .div_done(done_d), .mem_rdy(rdy_d), .stall_cnt(cnt_d));

  typedef struct {
    logic        r, id, dv, mm;
    logic [5:0]  stall;
    logic        start, done, rdy;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic r, logic id, logic dv, logic mm, logic [5:0] s,
                             logic st, logic dn, logic rd, int c);
    vec_t x;
    x.r = r; x.id = id; x.dv = dv; x.mm = mm;
    x.stall = s; x.start = st; x.done = dn; x.rdy = rd; x.cnt = 32'(c);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic r, input logic id, input logic dv, input logic mm);
    rst = r; stallreq_id = id; div_req = dv; mem_req = mm;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc;
    int ndone;
    bit  seen_done;

    // Table for DIV_CYCLES=4, MEM_WAIT=2:       r id dv mm  stall      st dn rd cnt
    vq.push_back(v(1, 1, 1, 1, 6'b000000, 0, 0, 0, 0));  // reset with all requests high
    vq.push_back(v(1, 1, 1, 1, 6'b000000, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 0, 0, 6'b000111, 0, 0, 0, 0));  // load-use pulse
    vq.push_back(v(0, 0, 0, 0, 6'b000000, 0, 0, 0, 1));
    vq.push_back(v(1, 0, 0, 0, 6'b000000, 0, 0, 0, 1));
    vq.push_back(v(0, 0, 1, 0, 6'b001111, 1, 0, 0, 0));  // div t0
    vq.push_back(v(0, 0, 1, 0, 6'b001111, 0, 0, 0, 1));
    vq.push_back(v(0, 0, 1, 0, 6'b001111, 0, 0, 0, 2));
    vq.push_back(v(0, 0, 1, 0, 6'b001111, 0, 0, 0, 3));
    vq.push_back(v(0, 0, 1, 0, 6'b001111, 0, 0, 0, 4));  // div t4
    vq.push_back(v(0, 0, 1, 0, 6'b000000, 0, 1, 0, 5));  // div t5 done
    vq.push_back(v(0, 0, 0, 0, 6'b000000, 0, 0, 0, 5));
    vq.push_back(v(0, 0, 0, 1, 6'b011111, 0, 0, 0, 5));  // mem t0
    vq.push_back(v(0, 0, 0, 1, 6'b011111, 0, 0, 0, 6));
    vq.push_back(v(0, 0, 0, 1, 6'b000000, 0, 0, 1, 7));  // mem t2 ready
    vq.push_back(v(0, 0, 0, 0, 6'b000000, 0, 0, 0, 7));
    vq.push_back(v(0, 0, 0, 1, 6'b011111, 0, 0, 0, 7));  // back-to-back accesses
    vq.push_back(v(0, 0, 0, 1, 6'b011111, 0, 0, 0, 8));
    vq.push_back(v(0, 0, 0, 1, 6'b000000, 0, 0, 1, 9));
    vq.push_back(v(0, 0, 0, 1, 6'b011111, 0, 0, 0, 9));
    vq.push_back(v(0, 0, 0, 1, 6'b011111, 0, 0, 0, 10));
    vq.push_back(v(0, 0, 0, 1, 6'b000000, 0, 0, 1, 11));
    vq.push_back(v(0, 1, 0, 0, 6'b000111, 0, 0, 0, 11));
    vq.push_back(v(0, 0, 0, 0, 6'b000000, 0, 0, 0, 12));
    vq.push_back(v(0, 1, 0, 1, 6'b011111, 0, 0, 0, 12)); // MEM outranks ID
    vq.push_back(v(0, 1, 0, 1, 6'b011111, 0, 0, 0, 13));
    vq.push_back(v(0, 1, 0, 1, 6'b000111, 0, 0, 1, 14));
    vq.push_back(v(0, 0, 0, 0, 6'b000000, 0, 0, 0, 15));
    vq.push_back(v(0, 0, 1, 0, 6'b001111, 1, 0, 0, 15)); // div aborted by reset
    vq.push_back(v(0, 0, 1, 0, 6'b001111, 0, 0, 0, 16));
    vq.push_back(v(1, 0, 1, 0, 6'b000000, 0, 0, 0, 17));
    vq.push_back(v(0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));

    drive(1, 0, 0, 0);
    next_cycle();

    foreach (vq[k]) begin
      drive(vq[k].r, vq[k].id, vq[k].dv, vq[k].mm);
      @(negedge clk);
      chk($sformatf("A[%0d].stall", k), 32'(stall_a), 32'(vq[k].stall));
      chk($sformatf("A[%0d].div_start", k), 32'(start_a), 32'(vq[k].start));
      chk($sformatf("A[%0d].div_done", k), 32'(done_a), 32'(vq[k].done));
      chk($sformatf("A[%0d].mem_rdy", k), 32'(rdy_a), 32'(vq[k].rdy));
      chk($sformatf("A[%0d].stall_cnt", k), cnt_a, vq[k].cnt);
      next_cycle();
    end

    // DIV_CYCLES=1, MEM_WAIT=3: divider result held in D_DONE while MEM waits
    drive(1, 0, 0, 0);
    next_cycle();
    drive(0, 0, 1, 1);
    @(negedge clk);
    chk("B.t0.stall", 32'(stall_b), 32'h1F);
    chk("B.t0.div_start", 32'(start_b), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("B.t1.stall", 32'(stall_b), 32'h1F);
    chk("B.t1.div_done", 32'(done_b), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("B.t2.stall", 32'(stall_b), 32'h1F);
    chk("B.t2.div_done", 32'(done_b), 32'd1);
    chk("B.t2.mem_rdy", 32'(rdy_b), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("B.t3.stall", 32'(stall_b), 32'h00);
    chk("B.t3.div_done", 32'(done_b), 32'd1);
    chk("B.t3.mem_rdy", 32'(rdy_b), 32'd1);
    next_cycle();
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("B.t4.stall", 32'(stall_b), 32'h00);
    chk("B.t4.div_done", 32'(done_b), 32'd0);
    chk("B.t4.mem_rdy", 32'(rdy_b), 32'd0);
    chk("B.t4.stall_cnt", cnt_b, 32'd3);
    next_cycle();

    // DIV_CYCLES=32: reset at cycle 2 aborts, then a full 33-cycle stall
    drive(1, 0, 0, 0);
    next_cycle();
    drive(0, 0, 1, 0);
    @(negedge clk);
    chk("C.t0.div_start", 32'(start_c), 32'd1);
    chk("C.t0.stall", 32'(stall_c), 32'h0F);
    next_cycle();
    @(negedge clk);
    chk("C.t1.stall", 32'(stall_c), 32'h0F);
    next_cycle();
    drive(1, 0, 1, 0);
    @(negedge clk);
    chk("C.rst.stall", 32'(stall_c), 32'h00);
    next_cycle();
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("C.after_rst.stall", 32'(stall_c), 32'h00);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      @(negedge clk);
      if (done_c) ndone++;
    end
    chk("C.aborted_div_done_count", 32'(ndone), 32'd0);
    next_cycle();
    drive(0, 0, 1, 0);
    ncyc = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall_c == 6'b0) begin
        seen_done = done_c;
        break;
      end
      if (stall_c == 6'b001111) ncyc++;
      next_cycle();
    end
    chk("C.div_stall_cycles", 32'(ncyc), 32'd33);
    chk("C.div_done_after_stall", 32'(seen_done), 32'd1);
    chk("C.stall_cnt", cnt_c, 32'd33);
    next_cycle();
    drive(0, 0, 0, 0);

    // MEM_WAIT=0: no wait states, ready follows the request
    drive(1, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("D.mem.stall", 32'(stall_d), 32'h00);
    chk("D.mem.mem_rdy", 32'(rdy_d), 32'd1);
    next_cycle();
    drive(0, 1, 0, 1);
    @(negedge clk);
    chk("D.id_mem.stall", 32'(stall_d), 32'h07);
    chk("D.id_mem.mem_rdy", 32'(rdy_d), 32'd1);
    next_cycle();
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("D.idle.mem_rdy", 32'(rdy_d), 32'd0);
    chk("D.idle.stall_cnt", cnt_d, 32'd1);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
